branch_resolution_unit: RTL
===========================

Name: branch_resolution_unit

Overview:
- Consumer side of the branch prediction interface. It records each prediction issued at decode in an in-flight queue.
- When the branch resolves in the memory stage, it compares the actual outcome with the recorded prediction.
- It drives the predictor's training signals (update address, actual decision, mispredict) and the pipeline's redirect/flush.
- It sits between the predictor, the decode stage and the memory-stage branch comparator.

Parameters:
- DEPTH, 4, in-flight branch queue entries; power of two, minimum 2.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- alloc_valid  input  1  decode stage issues a predicted branch this cycle.
- alloc_pc  input  32  PC of the branch.
- alloc_pred_taken  input  1  predictor's taken/not-taken decision.
- alloc_pred_target  input  32  predicted target (pc+offset).
- alloc_ready  output  1  queue can accept; equals !full, combinational.
- resolve_valid  input  1  memory stage resolves the oldest branch.
- resolve_taken  input  1  actual branch decision.
- resolve_target  input  32  actual computed target.
- update_valid  output  1  one-cycle pulse: predictor training strobe.
- update_branch_addr  output  32  PC of the resolved branch.
- actual_branch_decision  output  1  registered copy of resolve_taken.
- mispredict  output  1  resolved branch was mispredicted; valid with update_valid.
- redirect_valid  output  1  one-cycle pulse: fetch must restart.
- redirect_addr  output  32  correct next PC.
- flush  output  1  one-cycle pulse, coincident with redirect_valid.
- empty  output  1  no in-flight branches.
- full  output  1  DEPTH in-flight branches.
- branch_count  output  CNT_W  resolved branches, saturating.
- mispredict_count  output  CNT_W  mispredicted branches, saturating.
- protocol_error  output  1  sticky: resolve arrived with queue empty.

Behaviour:
- Reset (async, immediate):
  - queue emptied: head=tail=0, count=0; empty=1, full=0.
  - all outputs 0, counters 0, protocol_error 0.
- Entry = {pc[31:0], pred_taken, pred_target[31:0]}. Circular buffer with head/tail pointers mod DEPTH plus an occupancy count 0..DEPTH.
- Alloc:
  - accepted when alloc_valid & alloc_ready; written at tail; tail and count increment.
  - alloc_valid while full is dropped; no state change.
- Resolve (resolve_valid & !empty): head entry is consumed; head increments, count decrements.
  - Next cycle: update_valid=1, update_branch_addr=entry.pc, actual_branch_decision=resolve_taken, mispredict=M. Latency 1.
  - M = (pred_taken != resolve_taken) | (pred_taken & resolve_taken & pred_target != resolve_target).
  - If M: in the same output cycle, redirect_valid=1, flush=1, redirect_addr = resolve_taken ? resolve_target : pc+4 (32-bit wrap, 0xFFFFFFFC+4=0).
- Mispredict flush:
  - on the resolving edge, all remaining entries (younger, wrong-path) are discarded: head=tail, count=0.
  - an alloc in that same cycle is discarded (it is wrong-path).
- Simultaneous alloc and resolve, no mispredict: both take effect; count unchanged.
  - alloc_ready still reflects pre-edge full (no same-cycle bypass when full).
- Resolve while empty: ignored, no update pulse; protocol_error set and held until rst.
- Counters:
  - branch_count +1 per accepted resolve; mispredict_count +1 when M.
  - both saturate at 2^CNT_W-1, never wrap.
- Pulse outputs are single-cycle and deassert the following cycle unless a new resolve occurs; back-to-back resolves give back-to-back pulses.
- Reset mid-operation: all in-flight entries lost, any pending pulse suppressed.

Test Plan:
1. Alloc pc=0x100, pred_taken=1, target=0x140; resolve taken=1, target=0x140 -> next cycle update_valid=1, update_branch_addr=0x100, actual_branch_decision=1, mispredict=0, redirect_valid=0, branch_count=1.
2. Alloc pc=0x200, pred_taken=1, target=0x240; resolve taken=0 -> mispredict=1, redirect_valid=1, flush=1, redirect_addr=0x204, mispredict_count=1.
3. Alloc pc=0x300, pred_taken=1, target=0x310; resolve taken=1, target=0x320 -> mispredict=1, redirect_addr=0x320.
4. Fill 4 entries (pc 0x10,0x20,0x30,0x40): full=1, alloc_ready=0, a 5th alloc is dropped. Then resolve the oldest with a correct prediction -> update_branch_addr=0x10, count=3. Then resolve a misprediction on 0x20 -> empty=1 after flush, 0x30/0x40 never reported.
5. Resolve with queue empty -> no update_valid, protocol_error=1 and stays 1; assert rst mid-stream with 2 entries -> empty=1, counters=0, protocol_error=0.
6. Preload branch_count near saturation (CNT_W=4 build, 20 correct resolves) -> branch_count holds 15. pc=0xFFFFFFFC predicted taken, actually not taken -> redirect_addr=0x00000000.

Source files
------------

// File: rtl/branch_resolution_unit.sv
// ---------------------------------------------------------------------------
// branch_resolution_unit
//
// Purpose:
//   This is the consumer side of the branch prediction interface. Decode
//   records every predicted branch in a small in-flight queue. When the
//   memory stage resolves the oldest branch, the unit compares the actual
//   outcome with the recorded prediction. It then drives two sets of
//   outputs. The predictor training outputs are the update strobe, the
//   branch address, the actual decision and the mispredict flag. The
//   pipeline outputs are redirect and flush. It also keeps saturating
//   statistics counters.
//
// Handshake:
//   An alloc is accepted on a rising edge where alloc_valid && alloc_ready.
//   alloc_ready is !full and is combinational from the current occupancy. It
//   reflects the pre-edge state, so no slot freed by a same-cycle resolve can
//   be reused. A resolve is accepted on a rising edge where
//   resolve_valid && !empty. It always refers to the oldest in-flight entry.
//
// Ports:
//   clk, rst                   core clock, async active-high reset
//   alloc_valid/pc/pred_*      new predicted branch from decode
//   alloc_ready                queue can accept an alloc (!full)
//   resolve_valid/taken/target actual outcome of the oldest branch
//   update_valid               1-cycle training strobe (latency 1)
//   update_branch_addr         PC of the resolved branch
//   actual_branch_decision     registered resolve_taken
//   mispredict                 resolved branch was mispredicted
//   redirect_valid/flush       1-cycle pulses on a mispredict
//   redirect_addr              correct next PC after a mispredict
//   empty, full                queue occupancy status
//   branch_count               resolved branches (saturating)
//   mispredict_count           mispredicted branches (saturating)
//   protocol_error             sticky: resolve seen with an empty queue
// ---------------------------------------------------------------------------
module branch_resolution_unit #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   // decode-side allocation
   input  logic             alloc_valid,
   input  logic [31:0]      alloc_pc,
   input  logic             alloc_pred_taken,
   input  logic [31:0]      alloc_pred_target,
   output logic             alloc_ready,
   // memory-stage resolution
   input  logic             resolve_valid,
   input  logic             resolve_taken,
   input  logic [31:0]      resolve_target,
   // predictor training
   output logic             update_valid,
   output logic [31:0]      update_branch_addr,
   output logic             actual_branch_decision,
   output logic             mispredict,
   // pipeline control
   output logic             redirect_valid,
   output logic [31:0]      redirect_addr,
   output logic             flush,
   // status
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count,
   output logic             protocol_error
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   OCC_ONE   = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   OCC_DEPTH = (PTR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   // -----------------------------------------------------------------------
   // In-flight queue storage (no reset needed: occupancy qualifies it)
   // -----------------------------------------------------------------------
   logic [31:0] pc_mem_q    [DEPTH];
   logic        taken_mem_q [DEPTH];
   logic [31:0] tgt_mem_q   [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   occ_q,  occ_d;

   // -----------------------------------------------------------------------
   // Registered outputs
   // -----------------------------------------------------------------------
   logic             update_valid_q,   update_valid_d;
   logic [31:0]      update_addr_q,    update_addr_d;
   logic             actual_dec_q,     actual_dec_d;
   logic             mispredict_q,     mispredict_d;
   logic             redirect_valid_q, redirect_valid_d;
   logic [31:0]      redirect_addr_q,  redirect_addr_d;
   logic             flush_q,          flush_d;
   logic [CNT_W-1:0] branch_cnt_q,     branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q,    mispred_cnt_d;
   logic             proto_err_q,      proto_err_d;

   // -----------------------------------------------------------------------
   // Decode of the current cycle's events
   // -----------------------------------------------------------------------
   logic        is_empty;
   logic        is_full;
   logic        do_alloc;
   logic        do_resolve;
   logic        head_pred_taken;
   logic [31:0] head_pc;
   logic [31:0] head_pred_target;
   logic        mispredict_now;
   logic        flush_now;
   logic        alloc_write;

   assign is_empty = (occ_q == '0);
   assign is_full  = (occ_q == OCC_DEPTH);

   assign do_alloc   = alloc_valid & ~is_full;
   assign do_resolve = resolve_valid & ~is_empty;

   assign head_pc          = pc_mem_q[head_q];
   assign head_pred_taken  = taken_mem_q[head_q];
   assign head_pred_target = tgt_mem_q[head_q];

   // A taken/taken pair still mispredicts when the predicted target was wrong.
   assign mispredict_now = (head_pred_taken != resolve_taken) |
                           (head_pred_taken & resolve_taken &
                            (head_pred_target != resolve_target));

   assign flush_now = do_resolve & mispredict_now;

   // A same-cycle alloc during a flush is on the wrong path, so it is dropped.
   assign alloc_write = do_alloc & ~flush_now;

   // -----------------------------------------------------------------------
   // Queue pointer / occupancy next state
   // -----------------------------------------------------------------------
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (flush_now) begin
         // Consume the head, then discard every younger entry.
         head_d = head_q + PTR_ONE;
         tail_d = head_q + PTR_ONE;
         occ_d  = '0;
      end else begin
         if (alloc_write) begin
            tail_d = tail_q + PTR_ONE;
         end
         if (do_resolve) begin
            head_d = head_q + PTR_ONE;
         end
         case ({alloc_write, do_resolve})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Output / statistics next state
   // -----------------------------------------------------------------------
   always_comb begin
      update_valid_d   = do_resolve;
      mispredict_d     = flush_now;
      redirect_valid_d = flush_now;
      flush_d          = flush_now;
      update_addr_d    = update_addr_q;
      actual_dec_d     = actual_dec_q;
      redirect_addr_d  = redirect_addr_q;
      branch_cnt_d     = branch_cnt_q;
      mispred_cnt_d    = mispred_cnt_q;
      proto_err_d      = proto_err_q | (resolve_valid & is_empty);

      if (do_resolve) begin
         update_addr_d = head_pc;
         actual_dec_d  = resolve_taken;
         if (branch_cnt_q != CNT_MAX) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
         end
      end

      if (flush_now) begin
         // Fall-through wraps naturally in 32 bits.
         redirect_addr_d = resolve_taken ? resolve_target : (head_pc + 32'd4);
         if (mispred_cnt_q != CNT_MAX) begin
            mispred_cnt_d = mispred_cnt_q + CNT_ONE;
         end
      end
   end

   // -----------------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q           <= '0;
         tail_q           <= '0;
         occ_q            <= '0;
         update_valid_q   <= 1'b0;
         update_addr_q    <= '0;
         actual_dec_q     <= 1'b0;
         mispredict_q     <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_addr_q  <= '0;
         flush_q          <= 1'b0;
         branch_cnt_q     <= '0;
         mispred_cnt_q    <= '0;
         proto_err_q      <= 1'b0;
      end else begin
         head_q           <= head_d;
         tail_q           <= tail_d;
         occ_q            <= occ_d;
         update_valid_q   <= update_valid_d;
         update_addr_q    <= update_addr_d;
         actual_dec_q     <= actual_dec_d;
         mispredict_q     <= mispredict_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_addr_q  <= redirect_addr_d;
         flush_q          <= flush_d;
         branch_cnt_q     <= branch_cnt_d;
         mispred_cnt_q    <= mispred_cnt_d;
         proto_err_q      <= proto_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_write) begin
         pc_mem_q[tail_q]    <= alloc_pc;
         taken_mem_q[tail_q] <= alloc_pred_taken;
         tgt_mem_q[tail_q]   <= alloc_pred_target;
      end
   end

   // -----------------------------------------------------------------------
   // Output assignments
   // -----------------------------------------------------------------------
   assign alloc_ready            = ~is_full;
   assign empty                  = is_empty;
   assign full                   = is_full;
   assign update_valid           = update_valid_q;
   assign update_branch_addr     = update_addr_q;
   assign actual_branch_decision = actual_dec_q;
   assign mispredict             = mispredict_q;
   assign redirect_valid         = redirect_valid_q;
   assign redirect_addr          = redirect_addr_q;
   assign flush                  = flush_q;
   assign branch_count           = branch_cnt_q;
   assign mispredict_count       = mispred_cnt_q;
   assign protocol_error         = proto_err_q;

endmodule
